// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the hazard/forwarding controller of the 5-stage core:
//   FWD_RF/FWD_EX/FWD_MEM/FWD_WB : operand source select encodings
//   mdu_state_e                  : MDU occupancy FSM states
//   DIV_CYCLES_DEF/MUL_CYCLES_DEF: default MDU occupancy in cycles
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int DIV_CYCLES_DEF = 33;
    localparam int MUL_CYCLES_DEF = 2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline and the hazard controller.
//   slave  : seen by hazard_ctrl (pipeline state in, forwarding/stall out)
//   master : seen by the pipeline (drives pipeline state, consumes controls)
// Signals:
//   id_rs/id_rt, id_use_rs/id_use_rt, id_is_branch, id_use_hilo : ID stage
//   ex_reg/mem_reg/wb_reg, *_wreg, ex_mem_to_reg/mem_mem_to_reg  : writers
//   ex_mdu_start/ex_mdu_div : MDU issue in EX;  flush : flush from MEM
//   fwda/fwdb : operand source selects; stall_if/stall_id/bubble_ex : stalls
//   flush_all : clear front pipeline registers; mdu_busy : MDU occupied
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_is_branch;
    logic              id_use_hilo;
    logic [REG_AW-1:0] ex_reg;
    logic [REG_AW-1:0] mem_reg;
    logic [REG_AW-1:0] wb_reg;
    logic              ex_wreg;
    logic              mem_wreg;
    logic              wb_wreg;
    logic              ex_mem_to_reg;
    logic              mem_mem_to_reg;
    logic              ex_mdu_start;
    logic              ex_mdu_div;
    logic              flush;
    logic [1:0]        fwda;
    logic [1:0]        fwdb;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_all;
    logic              mdu_busy;

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_use_hilo,
        input  ex_reg, mem_reg, wb_reg, ex_wreg, mem_wreg, wb_wreg,
        input  ex_mem_to_reg, mem_mem_to_reg, ex_mdu_start, ex_mdu_div, flush,
        output fwda, fwdb, stall_if, stall_id, bubble_ex, flush_all, mdu_busy
    );

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_use_hilo,
        output ex_reg, mem_reg, wb_reg, ex_wreg, mem_wreg, wb_wreg,
        output ex_mem_to_reg, mem_mem_to_reg, ex_mdu_start, ex_mdu_div, flush,
        input  fwda, fwdb, stall_if, stall_id, bubble_ex, flush_all, mdu_busy
    );

endinterface

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Combinational forwarding priority select for one source operand.
// Ports:
//   src_i                 : source register read in ID
//   ex_reg_i/ex_wreg_i    : EX destination / write enable
//   ex_load_i             : EX holds a load (its result is not ready yet)
//   mem_reg_i/mem_wreg_i  : MEM destination / write enable
//   wb_reg_i/wb_wreg_i    : WB destination / write enable
//   sel_o                 : FWD_RF / FWD_EX / FWD_MEM / FWD_WB
// Priority EX > MEM > WB > regfile; r0 always reads the regfile.
// -----------------------------------------------------------------------------
module fwd_sel
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] ex_reg_i,
    input  logic              ex_wreg_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] mem_reg_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] wb_reg_i,
    input  logic              wb_wreg_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != '0) begin
            if (ex_wreg_i && !ex_load_i && (ex_reg_i == src_i)) begin
                sel_o = FWD_EX;
            end else if (mem_wreg_i && (mem_reg_i == src_i)) begin
                // A load in MEM still forwards from MEM: data is ready at
                // the end of the MEM stage.
                sel_o = FWD_MEM;
            end else if (wb_wreg_i && (wb_reg_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline interlock and forwarding controller for the 5-stage MIPS core.
// Ports:
//   clk     : core clock, rising edge
//   resetn  : synchronous active-low reset
//   hz      : hazard_ctrl_if.slave bundle (pipeline state in, controls out)
//   perf_lu/perf_br/perf_mdu : stall-cycle counters (HAZARD_PERF_EN only)
// Function:
//   - forwarding selects for rs/rt (combinational)
//   - load-use, branch-in-ID and MDU stalls combined into stall/bubble
//   - MDU occupancy FSM (IDLE/BUSY) with a countdown, registered mdu_busy
//   - flush overrides every stall and aborts a running MDU op
// Optional feature: define HAZARD_PERF_EN to add the three 32-bit
// saturating stall-cycle counters and their output ports.
// All combinational outputs are forced to 0 while resetn is low.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        resetn,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_br,
    output logic [31:0] perf_mdu
`endif
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    // ---------------- forwarding ----------------
    logic [REG_AW-1:0] src [2];
    logic [1:0]        sel [2];

    assign src[0] = hz.id_rs;
    assign src[1] = hz.id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
                .src_i     (src[gi]),
                .ex_reg_i  (hz.ex_reg),
                .ex_wreg_i (hz.ex_wreg),
                .ex_load_i (hz.ex_mem_to_reg),
                .mem_reg_i (hz.mem_reg),
                .mem_wreg_i(hz.mem_wreg),
                .wb_reg_i  (hz.wb_reg),
                .wb_wreg_i (hz.wb_wreg),
                .sel_o     (sel[gi])
            );
        end
    endgenerate

    assign hz.fwda = resetn ? sel[0] : FWD_RF;
    assign hz.fwdb = resetn ? sel[1] : FWD_RF;

    // ---------------- stall conditions ----------------
    logic ex_hit, mem_hit;
    logic lu_cond, br_cond, mdu_cond, any_stall;

    // A destination hits when it is nonzero and equals a source ID really reads.
    assign ex_hit  = (hz.ex_reg != '0) &&
                     ((hz.id_use_rs && (hz.ex_reg == hz.id_rs)) ||
                      (hz.id_use_rt && (hz.ex_reg == hz.id_rt)));
    assign mem_hit = (hz.mem_reg != '0) &&
                     ((hz.id_use_rs && (hz.mem_reg == hz.id_rs)) ||
                      (hz.id_use_rt && (hz.mem_reg == hz.id_rt)));

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mdu_busy_q;

    assign mdu_busy_q = (state_q == MDU_BUSY);

    assign lu_cond  = hz.ex_mem_to_reg & ex_hit;
    assign br_cond  = hz.id_is_branch &
                      ((hz.ex_wreg & ex_hit) | (hz.mem_mem_to_reg & mem_hit));
    // The issue cycle itself already blocks HI/LO users.
    assign mdu_cond = (mdu_busy_q | hz.ex_mdu_start) & hz.id_use_hilo;

    assign any_stall    = resetn & ~hz.flush & (lu_cond | br_cond | mdu_cond);
    assign hz.stall_if  = any_stall;
    assign hz.stall_id  = any_stall;
    assign hz.bubble_ex = any_stall;
    assign hz.flush_all = resetn & hz.flush;
    assign hz.mdu_busy  = mdu_busy_q;

    // ---------------- MDU occupancy FSM ----------------
    logic [CNT_W-1:0] start_load;
    assign start_load = hz.ex_mdu_div ? DIV_LOAD : MUL_LOAD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hz.flush) begin
            // Flush aborts the op and swallows a simultaneous start.
            state_d = MDU_IDLE;
            cnt_d   = '0;
        end else if (hz.ex_mdu_start) begin
            // A start while BUSY simply reloads. A one-cycle op never
            // occupies the MDU beyond its issue cycle.
            if (start_load == '0) begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = MDU_BUSY;
                cnt_d   = start_load;
            end
        end else if (state_q == MDU_BUSY) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // ---------------- stall-cycle counters ----------------
    // Counted on the raw conditions, so flush does not hide them.
    logic [31:0] perf_q [3];
    logic        perf_cond [3];

    assign perf_cond[0] = lu_cond;
    assign perf_cond[1] = br_cond;
    assign perf_cond[2] = mdu_cond;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    perf_q[gi] <= '0;
                end else if (perf_cond[gi] && (perf_q[gi] != '1)) begin
                    perf_q[gi] <= perf_q[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_lu  = perf_q[0];
    assign perf_br  = perf_q[1];
    assign perf_mdu = perf_q[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed test of hazard_ctrl. Inputs change 1 time unit after the rising
// edge; a single checker on the falling edge compares every output with a
// behavioural model and, on marked steps, with hand-written literal values.
// Define HAZARD_PERF_EN to also cover the stall-cycle counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int DIV_N  = 33;
    localparam int MUL_N  = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu, perf_br, perf_mdu;
`endif

    hazard_ctrl #(
        .REG_AW    (REG_AW),
        .DIV_CYCLES(DIV_N),
        .MUL_CYCLES(MUL_N),
        .CNT_W     (6)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .hz      (bus)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu (perf_lu),
        .perf_br (perf_br),
        .perf_mdu(perf_mdu)
`endif
    );

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    // ---------------- literal expectations from the stimulus ----------------
    logic       lit_on = 1'b0;
    string      lit_name = "";
    logic [1:0] lit_fa, lit_fb;
    logic       lit_st, lit_fl, lit_bz;
    int         lit_plu = -1;

    // ---------------- behavioural model state ----------------
    int cyc = 0;
    int issue_cyc = 0;
    int issue_n = 0;       // occupancy of the last accepted MDU op, 0 = none
    int m_lu = 0, m_br = 0, m_mdu = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] s);
        if (s == 0) return 2'd0;
        if (bus.ex_wreg && !bus.ex_mem_to_reg && bus.ex_reg == s) return 2'd1;
        if (bus.mem_wreg && bus.mem_reg == s) return 2'd2;
        if (bus.wb_wreg && bus.wb_reg == s) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic m_hit(input logic [REG_AW-1:0] r);
        return (r != 0) && ((bus.id_use_rs && r == bus.id_rs) ||
                            (bus.id_use_rt && r == bus.id_rt));
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic e_busy, lu, br, md, e_st, e_fl;
        logic [1:0] e_fa, e_fb;
        int age;
        age    = cyc - issue_cyc;
        e_busy = (issue_n > 0) && (age >= 1) && (age < issue_n);
        lu     = bus.ex_mem_to_reg && m_hit(bus.ex_reg);
        br     = bus.id_is_branch && ((bus.ex_wreg && m_hit(bus.ex_reg)) ||
                                      (bus.mem_mem_to_reg && m_hit(bus.mem_reg)));
        md     = (e_busy || bus.ex_mdu_start) && bus.id_use_hilo;
        e_st   = resetn && !bus.flush && (lu || br || md);
        e_fl   = resetn && bus.flush;
        e_fa   = resetn ? m_fwd(bus.id_rs) : 2'd0;
        e_fb   = resetn ? m_fwd(bus.id_rt) : 2'd0;

        chk("fwda",      32'(bus.fwda),      32'(e_fa));
        chk("fwdb",      32'(bus.fwdb),      32'(e_fb));
        chk("stall_if",  32'(bus.stall_if),  32'(e_st));
        chk("stall_id",  32'(bus.stall_id),  32'(e_st));
        chk("bubble_ex", 32'(bus.bubble_ex), 32'(e_st));
        chk("flush_all", 32'(bus.flush_all), 32'(e_fl));
        chk("mdu_busy",  32'(bus.mdu_busy),  32'(e_busy));
`ifdef HAZARD_PERF_EN
        chk("perf_lu",  perf_lu,  32'(m_lu));
        chk("perf_br",  perf_br,  32'(m_br));
        chk("perf_mdu", perf_mdu, 32'(m_mdu));
`endif

        if (lit_on) begin
            chk({lit_name, ".fwda"},      32'(bus.fwda),     32'(lit_fa));
            chk({lit_name, ".fwdb"},      32'(bus.fwdb),     32'(lit_fb));
            chk({lit_name, ".stall"},     32'(bus.stall_id), 32'(lit_st));
            chk({lit_name, ".flush_all"}, 32'(bus.flush_all),32'(lit_fl));
            chk({lit_name, ".mdu_busy"},  32'(bus.mdu_busy), 32'(lit_bz));
            chk({lit_name, ".model_st"},  32'(e_st),         32'(lit_st));
            chk({lit_name, ".model_bz"},  32'(e_busy),       32'(lit_bz));
`ifdef HAZARD_PERF_EN
            if (lit_plu >= 0) chk({lit_name, ".perf_lu"}, perf_lu, 32'(lit_plu));
`endif
        end

        // model effects of the coming edge
        if (!resetn || bus.flush) begin
            issue_n = 0;
        end else if (bus.ex_mdu_start) begin
            issue_cyc = cyc;
            issue_n   = bus.ex_mdu_div ? DIV_N : MUL_N;
        end
        if (!resetn) begin
            m_lu = 0; m_br = 0; m_mdu = 0;
        end else begin
            if (lu) m_lu++;
            if (br) m_br++;
            if (md) m_mdu++;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic clear();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_is_branch = 0; bus.id_use_hilo = 0;
        bus.ex_reg = '0; bus.mem_reg = '0; bus.wb_reg = '0;
        bus.ex_wreg = 0; bus.mem_wreg = 0; bus.wb_wreg = 0;
        bus.ex_mem_to_reg = 0; bus.mem_mem_to_reg = 0;
        bus.ex_mdu_start = 0; bus.ex_mdu_div = 0; bus.flush = 0;
    endtask

    // Hold current inputs for one cycle; optionally attach literal expectations.
    task automatic tick(input bit lit, input string nm, input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic fl, input logic bz);
        lit_on = lit; lit_name = nm;
        lit_fa = fa; lit_fb = fb; lit_st = st; lit_fl = fl; lit_bz = bz;
        if (lit) $display("step %-16s fwda=%0d fwdb=%0d stall=%0d flush_all=%0d mdu_busy=%0d",
                          nm, fa, fb, st, fl, bz);
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, "", 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        clear();
        @(posedge clk);
        #1;

        // reset: matching inputs and flush must not leak to the outputs
        bus.ex_wreg = 1; bus.ex_reg = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1; bus.flush = 1;
        tick(1, "reset", 0, 0, 0, 0, 0);
        tick(1, "reset2", 0, 0, 0, 0, 0);

        resetn = 1'b1;
        clear();
        bus.ex_wreg = 1; bus.ex_reg = 5'd8; bus.mem_wreg = 1; bus.mem_reg = 5'd8;
        bus.wb_wreg = 1; bus.wb_reg = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1;
        tick(1, "fwd_ex", 2'd1, 0, 0, 0, 0);
        bus.ex_wreg = 0;
        tick(1, "fwd_mem", 2'd2, 0, 0, 0, 0);
        bus.mem_wreg = 0;
        tick(1, "fwd_wb", 2'd3, 0, 0, 0, 0);
        bus.ex_wreg = 1; bus.ex_mem_to_reg = 1; bus.mem_wreg = 1;
        tick(1, "fwd_skip_load", 2'd2, 0, 1, 0, 0);

        clear();
        bus.ex_wreg = 1; bus.ex_mem_to_reg = 1; bus.ex_reg = 5'd9;
        bus.id_rt = 5'd9; bus.id_use_rt = 1;
        tick(1, "load_use", 0, 0, 1, 0, 0);
        clear();
        bus.mem_wreg = 1; bus.mem_mem_to_reg = 1; bus.mem_reg = 5'd9;
        bus.id_rt = 5'd9; bus.id_use_rt = 1;
        tick(1, "load_fwd", 0, 2'd2, 0, 0, 0);

        clear();
        bus.id_is_branch = 1; bus.id_rs = 5'd5; bus.id_use_rs = 1;
        bus.ex_wreg = 1; bus.ex_reg = 5'd5;
        tick(1, "br_ex", 2'd1, 0, 1, 0, 0);
        bus.id_rs = 5'd0; bus.ex_reg = 5'd0;
        tick(1, "br_r0", 0, 0, 0, 0, 0);
        clear();
        bus.id_is_branch = 1; bus.id_rt = 5'd6; bus.id_use_rt = 1;
        bus.mem_wreg = 1; bus.mem_mem_to_reg = 1; bus.mem_reg = 5'd6;
        tick(1, "br_mem_load", 0, 2'd2, 1, 0, 0);
        bus.id_use_rt = 0;
        tick(1, "br_unused", 0, 2'd2, 0, 0, 0);

        // divide with mflo waiting in ID
        clear();
        bus.ex_mdu_start = 1; bus.ex_mdu_div = 1; bus.id_use_hilo = 1;
        tick(1, "div_issue", 0, 0, 1, 0, 0);
        bus.ex_mdu_start = 0; bus.ex_mdu_div = 0;
        for (int i = 1; i <= DIV_N - 1; i++) begin
            if (i == 1)              tick(1, "div_busy_first", 0, 0, 1, 0, 1);
            else if (i == DIV_N - 1) tick(1, "div_busy_last", 0, 0, 1, 0, 1);
            else                     tick(0, "", 0, 0, 0, 0, 0);
        end
        tick(1, "div_done", 0, 0, 0, 0, 0);

        // multiply
        clear();
        bus.ex_mdu_start = 1;
        tick(1, "mul_issue", 0, 0, 0, 0, 0);
        bus.ex_mdu_start = 0;
        tick(1, "mul_busy", 0, 0, 0, 0, 1);
        tick(1, "mul_done", 0, 0, 0, 0, 0);

        // flush while a divide is in flight (counter at 10)
        clear();
        bus.ex_mdu_start = 1; bus.ex_mdu_div = 1;
        run(1);
        bus.ex_mdu_start = 0; bus.ex_mdu_div = 0;
        run(22);
        bus.flush = 1; bus.id_use_hilo = 1;
        tick(1, "flush_mid", 0, 0, 0, 1, 1);
        bus.flush = 0;
        tick(1, "after_flush", 0, 0, 0, 0, 0);

        // flush swallows a simultaneous start
        clear();
        bus.flush = 1; bus.ex_mdu_start = 1; bus.ex_mdu_div = 1;
        tick(1, "flush_start", 0, 0, 0, 1, 0);
        clear();
        tick(1, "flush_start_nx", 0, 0, 0, 0, 0);

        // reset while busy
        bus.ex_mdu_start = 1; bus.ex_mdu_div = 1;
        run(1);
        bus.ex_mdu_start = 0; bus.ex_mdu_div = 0;
        run(5);
        resetn = 0; bus.id_use_hilo = 1;
        tick(1, "reset_busy", 0, 0, 0, 0, 1);
        resetn = 1;
        tick(1, "reset_after", 0, 0, 0, 0, 0);

        // three load-use stalls, then counters are visible
        clear();
        bus.ex_wreg = 1; bus.ex_mem_to_reg = 1; bus.ex_reg = 5'd3;
        bus.id_rs = 5'd3; bus.id_use_rs = 1;
        run(3);
        clear();
        lit_plu = 3;
        tick(1, "perf_check", 0, 0, 0, 0, 0);
        lit_plu = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
